// File: rtl/axis_packer_pkg.sv
// Shared types and constants for the 16-to-32-bit AXI-Stream sample packer:
// data widths, byte-enable patterns and the packing FSM state type.
package axis_packer_pkg;

    localparam int IN_W   = 16;
    localparam int OUT_W  = 32;
    localparam int KEEP_W = OUT_W / 8;

    localparam logic [KEEP_W-1:0] KEEP_FULL = 4'b1111;
    localparam logic [KEEP_W-1:0] KEEP_HALF = 4'b0011;

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } pack_state_e;

endpackage

// File: rtl/axis_sample_packer.sv
// Packs pairs of 16-bit AXI-Stream samples into 32-bit words (first sample low).
// Optional frame counter output enabled by defining AXIS_SAMPLE_PACKER_FRAME_CNT_EN.
module axis_sample_packer
    import axis_packer_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic [IN_W-1:0]   s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic [OUT_W-1:0]  m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready
`ifdef AXIS_SAMPLE_PACKER_FRAME_CNT_EN
    ,
    output logic [15:0]       frame_count
`endif
);

    pack_state_e       state_q;
    logic [IN_W-1:0]   lo_q;
    logic [OUT_W-1:0]  tdata_q;
    logic [KEEP_W-1:0] tkeep_q;
    logic              tvalid_q;
    logic              tlast_q;

    logic in_fire;
    logic out_fire;

    // A new word may only be loaded when the output slot is free or draining now,
    // which also keeps the held word stable under backpressure.
    assign s_axis_tready = resetn & (~tvalid_q | m_axis_tready);
    assign in_fire       = s_axis_tvalid & s_axis_tready;
    assign out_fire      = tvalid_q & m_axis_tready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= EMPTY;
            lo_q     <= '0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else begin
            if (out_fire) begin
                tvalid_q <= 1'b0;
            end
            if (in_fire) begin
                case (state_q)
                    EMPTY: begin
                        if (s_axis_tlast) begin
                            tdata_q  <= {{(OUT_W-IN_W){1'b0}}, s_axis_tdata};
                            tkeep_q  <= KEEP_HALF;
                            tlast_q  <= 1'b1;
                            tvalid_q <= 1'b1;
                        end else begin
                            lo_q    <= s_axis_tdata;
                            state_q <= HALF;
                        end
                    end
                    HALF: begin
                        tdata_q  <= {s_axis_tdata, lo_q};
                        tkeep_q  <= KEEP_FULL;
                        tlast_q  <= s_axis_tlast;
                        tvalid_q <= 1'b1;
                        state_q  <= EMPTY;
                    end
                    default: state_q <= EMPTY;
                endcase
            end
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;

`ifdef AXIS_SAMPLE_PACKER_FRAME_CNT_EN
    logic [15:0] frame_count_q;
    logic [15:0] frame_count_d;

    always_comb begin
        frame_count_d = frame_count_q;
        if (out_fire && tlast_q) begin
            frame_count_d = frame_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frame_count_q <= '0;
        end else begin
            frame_count_q <= frame_count_d;
        end
    end

    assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_axis_sample_packer.sv
// Self-checking bench for axis_sample_packer: vector table, scoreboard queue,
// and hand-written stall / reset / throughput sequences.
module tb_axis_sample_packer;

    logic        clk = 1'b0;
    logic        resetn;
    logic [15:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready;
`ifdef AXIS_SAMPLE_PACKER_FRAME_CNT_EN
    logic [15:0] frame_count;
`endif

    always #5 clk = ~clk;

    axis_sample_packer dut (
        .clk           (clk),
        .resetn        (resetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready)
`ifdef AXIS_SAMPLE_PACKER_FRAME_CNT_EN
        ,
        .frame_count   (frame_count)
`endif
    );

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    typedef struct packed {
        logic [15:0] d;
        logic        l;
        logic        out;
        word_t       w;
    } vec_t;

    int    cmp_count  = 0;
    int    fail_count = 0;
    int    last_seen  = 0;
    word_t exp_q[$];
    word_t mon_e;
    vec_t  vecs[10];
    bit    bp_en = 1'b0;

    function automatic word_t mk(input logic [31:0] d, input logic [3:0] k, input logic l);
        word_t w;
        w.data = d;
        w.keep = k;
        w.last = l;
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_count++;
        if (act !== exp) begin
            fail_count++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: pop and compare every completed output beat.
    always @(negedge clk) begin
        if (resetn === 1'b1 && m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
            if (exp_q.size() == 0) begin
                cmp_count++;
                fail_count++;
                $display("FAIL unexpected_word: got %h expected none", m_axis_tdata);
            end else begin
                mon_e = exp_q.pop_front();
                $display("word %h keep %h last %0d (expected %h %h %0d)",
                         m_axis_tdata, m_axis_tkeep, m_axis_tlast,
                         mon_e.data, mon_e.keep, mon_e.last);
                check("word_data", m_axis_tdata, mon_e.data);
                check("word_keep", {28'h0, m_axis_tkeep}, {28'h0, mon_e.keep});
                check("word_last", {31'h0, m_axis_tlast}, {31'h0, mon_e.last});
                if (mon_e.last) last_seen++;
            end
        end
    end

    task automatic send(input logic [15:0] d, input logic l, input logic out, input word_t w);
        int n;
        n = 0;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_axis_tready) break;
            n++;
            if (n > 500) begin
                cmp_count++;
                fail_count++;
                $display("FAIL send_timeout: got s_axis_tready 0 expected 1");
                break;
            end
        end
        if (out) exp_q.push_back(w);
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        logic [15:0] lo;
        bit          have;
        logic [15:0] d;
        logic        l;
        time         t0;

        vecs[0] = '{16'h0001, 1'b0, 1'b0, mk(32'h0, 4'h0, 1'b0)};
        vecs[1] = '{16'h0002, 1'b0, 1'b1, mk(32'h00020001, 4'hF, 1'b0)};
        vecs[2] = '{16'h0003, 1'b0, 1'b0, mk(32'h0, 4'h0, 1'b0)};
        vecs[3] = '{16'h0004, 1'b1, 1'b1, mk(32'h00040003, 4'hF, 1'b1)};
        vecs[4] = '{16'h00AA, 1'b0, 1'b0, mk(32'h0, 4'h0, 1'b0)};
        vecs[5] = '{16'h00BB, 1'b0, 1'b1, mk(32'h00BB00AA, 4'hF, 1'b0)};
        vecs[6] = '{16'h00CC, 1'b1, 1'b1, mk(32'h000000CC, 4'h3, 1'b1)};
        vecs[7] = '{16'h0011, 1'b0, 1'b0, mk(32'h0, 4'h0, 1'b0)};
        vecs[8] = '{16'h0022, 1'b1, 1'b1, mk(32'h00220011, 4'hF, 1'b1)};
        vecs[9] = '{16'h0FFF, 1'b1, 1'b1, mk(32'h00000FFF, 4'h3, 1'b1)};

        resetn        = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_s_tready", {31'h0, s_axis_tready}, 32'h0);
        check("reset_m_tvalid", {31'h0, m_axis_tvalid}, 32'h0);
        check("reset_m_tdata",  m_axis_tdata, 32'h0);
        check("reset_m_tkeep",  {28'h0, m_axis_tkeep}, 32'h0);
        check("reset_m_tlast",  {31'h0, m_axis_tlast}, 32'h0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Vector table with the sink always ready; also checks 1-cycle latency.
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].d, vecs[i].l, vecs[i].out, vecs[i].w);
            if (vecs[i].out) begin
                check($sformatf("latency_valid_%0d", i), {31'h0, m_axis_tvalid}, 32'h1);
                check($sformatf("latency_data_%0d", i), m_axis_tdata, vecs[i].w.data);
            end
        end
        drain();

        // Backpressure: a word is pending and the sink stalls for 10 cycles.
        send(16'h00A1, 1'b0, 1'b0, mk(32'h0, 4'h0, 1'b0));
        m_axis_tready = 1'b0;
        send(16'h00A2, 1'b0, 1'b1, mk(32'h00A200A1, 4'hF, 1'b0));
        s_axis_tdata  = 16'h00A3;
        s_axis_tlast  = 1'b0;
        s_axis_tvalid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("stall_s_tready", {31'h0, s_axis_tready}, 32'h0);
            check("stall_m_tvalid", {31'h0, m_axis_tvalid}, 32'h1);
            check("stall_m_tdata",  m_axis_tdata, 32'h00A200A1);
            check("stall_m_tkeep",  {28'h0, m_axis_tkeep}, 32'hF);
        end
        @(posedge clk);
        #1;
        m_axis_tready = 1'b1;
        send(16'h00A3, 1'b0, 1'b0, mk(32'h0, 4'h0, 1'b0));
        send(16'h00A4, 1'b1, 1'b1, mk(32'h00A400A3, 4'hF, 1'b1));
        drain();

        // Sustained throughput: 8 samples must take exactly 8 cycles.
        t0 = $time;
        for (int i = 0; i < 8; i++) begin
            d = 16'h0100 + 16'(i);
            if (i % 2 == 1)
                send(d, (i == 7), 1'b1, mk({d, d - 16'h1}, 4'hF, (i == 7)));
            else
                send(d, 1'b0, 1'b0, mk(32'h0, 4'h0, 1'b0));
        end
        check("throughput_cycles", 32'(($time - t0) / 10), 32'd8);
        drain();

        // Random frames under random sink backpressure.
        bp_en = 1'b1;
        fork
            begin
                while (bp_en) begin
                    @(posedge clk);
                    #1;
                    m_axis_tready = ($urandom_range(0, 2) != 0);
                end
                m_axis_tready = 1'b1;
            end
        join_none
        have = 1'b0;
        lo   = '0;
        for (int i = 0; i < 40; i++) begin
            d = 16'($urandom);
            l = (i == 39) || ($urandom_range(0, 4) == 0);
            if (!have) begin
                if (l) send(d, l, 1'b1, mk({16'h0, d}, 4'h3, 1'b1));
                else begin
                    send(d, l, 1'b0, mk(32'h0, 4'h0, 1'b0));
                    lo   = d;
                    have = 1'b1;
                end
            end else begin
                send(d, l, 1'b1, mk({d, lo}, 4'hF, l));
                have = 1'b0;
            end
        end
        bp_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_axis_tready = 1'b1;
        drain();

        // Reset while a half-word is held.
        send(16'h1234, 1'b0, 1'b0, mk(32'h0, 4'h0, 1'b0));
        resetn = 1'b0;
        #1;
        check("midreset_m_tvalid", {31'h0, m_axis_tvalid}, 32'h0);
        check("midreset_s_tready", {31'h0, s_axis_tready}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check("postreset_m_tvalid", {31'h0, m_axis_tvalid}, 32'h0);
        send(16'h5555, 1'b0, 1'b0, mk(32'h0, 4'h0, 1'b0));
        send(16'h6666, 1'b1, 1'b1, mk(32'h66665555, 4'hF, 1'b1));
        check("postreset_data", m_axis_tdata, 32'h66665555);
        drain();

`ifdef AXIS_SAMPLE_PACKER_FRAME_CNT_EN
        last_seen = 0;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        check("frame_count_reset", {16'h0, frame_count}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            send(16'h0F00 + 16'(i), 1'b1, 1'b1, mk({16'h0, 16'h0F00 + 16'(i)}, 4'h3, 1'b1));
        end
        drain();
        @(posedge clk);
        #1;
        check("frame_count_value", {16'h0, frame_count}, 32'(last_seen));
        check("frame_count_five", {16'h0, frame_count}, 32'd5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", cmp_count, fail_count);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
